// File: rtl/ctrl_pipe_unit_pkg.sv
// Shared types for the ID-stage control pipeline: opcode classes, instruction
// classes, branch funct3 codes, the ID->EX control bundle and controller state.
package ctrl_pipe_unit_pkg;

    typedef logic [6:0] instruction_format_type;

    localparam instruction_format_type OPC_LOAD    = 7'b0000011;
    localparam instruction_format_type OPC_LOAD_FP = 7'b0000111;
    localparam instruction_format_type OPC_LUI     = 7'b0110111;
    localparam instruction_format_type OPC_AUIPC   = 7'b0010111;

    typedef enum logic [2:0] {
        OPT_R = 3'd0,
        OPT_I = 3'd1,
        OPT_S = 3'd2,
        OPT_B = 3'd3,
        OPT_U = 3'd4,
        OPT_J = 3'd5
    } instruction_op_type;

    localparam logic [2:0] BEQ  = 3'b000;
    localparam logic [2:0] BNE  = 3'b001;
    localparam logic [2:0] BLT  = 3'b100;
    localparam logic [2:0] BGE  = 3'b101;
    localparam logic [2:0] BLTU = 3'b110;
    localparam logic [2:0] BGEU = 3'b111;

    typedef struct packed {
        logic       mem_write;
        logic       mem2reg;
        logic       reg_write;
        logic       alu_src;
        logic       auipc;
        logic       is_compressed;
        logic [2:0] load_size;
        logic [2:0] store_size;
        logic [4:0] rd;
    } ctrl_bundle_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        SQUASH = 2'd2
    } ctrl_state_t;

    // Classes are matched on bits [6:2] so compressed encodings, whose low
    // bits differ, still fall into the same opcode class.
    function automatic logic opc_match(input instruction_format_type opc,
                                       input instruction_format_type cls);
        return opc[6:2] == cls[6:2];
    endfunction

endpackage

// File: rtl/ctrl_pipe_unit_branch_compare.sv
// Combinational branch-condition evaluator: equality, signed and unsigned
// less-than selected by the B-type funct3.
module branch_compare
    import ctrl_pipe_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] op_a_i,
    input  logic [XLEN-1:0] op_b_i,
    output logic            taken_o
);

    logic eq;
    logic lt_s;
    logic lt_u;

    assign eq   = (op_a_i == op_b_i);
    assign lt_s = ($signed(op_a_i) < $signed(op_b_i));
    assign lt_u = ($unsigned(op_a_i) < $unsigned(op_b_i));

    always_comb begin
        taken_o = 1'b0;
        case (funct3_i)
            BEQ:     taken_o = eq;
            BNE:     taken_o = !eq;
            BLT:     taken_o = lt_s;
            BGE:     taken_o = !lt_s;
            BLTU:    taken_o = lt_u;
            BGEU:    taken_o = !lt_u;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/ctrl_pipe_unit.sv
// ID-stage decode/control with in-ID branch resolution, load-use hazard
// stalling, wrong-path squashing and a registered, back-pressurable ID->EX stage.
module ctrl_pipe_unit
    import ctrl_pipe_unit_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  instruction_format_type opcode,
    input  instruction_op_type     optype,
    input  logic [2:0]             funct3,
    input  logic [4:0]             rd,
    input  logic [4:0]             rs1,
    input  logic [4:0]             rs2,
    input  logic [XLEN-1:0]        rs1_data,
    input  logic [XLEN-1:0]        rs2_data,
    input  logic                   ex_ready,
    output logic                   id_stall,
    output logic                   ex_valid,
    output ctrl_bundle_t           ex_ctrl,
    output logic                   redirect,
    output logic [CNT_W-1:0]       stall_count,
    output logic [CNT_W-1:0]       flush_count
);

    localparam logic [2:0] SQUASH_INIT = 3'(FLUSH_CYCLES);

    // Handshake: the ID instruction is consumed on a rising edge where
    // ex_ready=1 and id_stall=0; ex_ready=0 freezes both ID and the EX register.

    ctrl_state_t      state_q, state_d;
    logic [2:0]       squash_q, squash_d;
    logic             ex_valid_q, ex_valid_d;
    ctrl_bundle_t     ex_ctrl_q, ex_ctrl_d;
    logic             redirect_q, redirect_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] flush_q, flush_d;
    logic             stall_inc, flush_inc;

    ctrl_bundle_t dec;
    logic         is_load, is_lui, is_auipc;
    logic         use_rs1, use_rs2, hazard;
    logic         br_taken, taken;

    branch_compare #(.XLEN(XLEN)) u_branch_compare (
        .funct3_i (funct3),
        .op_a_i   (rs1_data),
        .op_b_i   (rs2_data),
        .taken_o  (br_taken)
    );

    assign is_load  = opc_match(opcode, OPC_LOAD) || opc_match(opcode, OPC_LOAD_FP);
    assign is_lui   = opc_match(opcode, OPC_LUI);
    assign is_auipc = opc_match(opcode, OPC_AUIPC);

    always_comb begin
        dec = '0;
        if (id_valid) begin
            dec.is_compressed = (opcode[1:0] != 2'b11);
            dec.rd            = rd;
            case (optype)
                OPT_R: dec.reg_write = 1'b1;
                OPT_I: begin
                    dec.reg_write = 1'b1;
                    dec.alu_src   = 1'b1;
                    if (is_load) begin
                        dec.mem2reg   = 1'b1;
                        dec.load_size = funct3;
                    end
                end
                OPT_S: begin
                    dec.alu_src    = 1'b1;
                    dec.mem_write  = 1'b1;
                    dec.store_size = funct3;
                end
                OPT_U: begin
                    dec.reg_write = is_lui || is_auipc;
                    dec.alu_src   = is_lui || is_auipc;
                    dec.auipc     = is_auipc;
                end
                OPT_J:   dec.reg_write = 1'b1;
                default: dec = dec;
            endcase
        end
    end

    assign use_rs1 = (optype == OPT_R) || (optype == OPT_I) || (optype == OPT_S) || (optype == OPT_B);
    assign use_rs2 = (optype == OPT_R) || (optype == OPT_S) || (optype == OPT_B);
    assign hazard  = id_valid && ex_valid_q && ex_ctrl_q.mem2reg && (ex_ctrl_q.rd != 5'd0) &&
                     ((use_rs1 && (rs1 == ex_ctrl_q.rd)) || (use_rs2 && (rs2 == ex_ctrl_q.rd)));
    assign taken   = id_valid && (((optype == OPT_B) && br_taken) || (optype == OPT_J));

    // STALL only marks the bubble cycle; it re-evaluates exactly like RUN.
    always_comb begin
        state_d    = state_q;
        squash_d   = squash_q;
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        redirect_d = 1'b0;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        id_stall   = 1'b0;
        if (!ex_ready) begin
            id_stall = 1'b1;
        end else if (state_q == SQUASH) begin
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            if (id_valid) begin
                flush_inc = 1'b1;
                squash_d  = squash_q - 3'd1;
                if (squash_q == 3'd1) state_d = RUN;
            end
        end else if (hazard) begin
            id_stall   = 1'b1;
            ex_valid_d = 1'b0;
            ex_ctrl_d  = '0;
            stall_inc  = 1'b1;
            state_d    = STALL;
        end else begin
            ex_valid_d = id_valid;
            ex_ctrl_d  = dec;
            state_d    = RUN;
            if (taken) begin
                redirect_d = 1'b1;
                if (FLUSH_CYCLES > 0) begin
                    squash_d = SQUASH_INIT;
                    state_d  = SQUASH;
                end
            end
        end
    end

    assign stall_d = (stall_inc && (stall_q != '1)) ? stall_q + CNT_W'(1) : stall_q;
    assign flush_d = (flush_inc && (flush_q != '1)) ? flush_q + CNT_W'(1) : flush_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= RUN;
            squash_q   <= 3'd0;
            ex_valid_q <= 1'b0;
            ex_ctrl_q  <= '0;
            redirect_q <= 1'b0;
            stall_q    <= '0;
            flush_q    <= '0;
        end else begin
            state_q    <= state_d;
            squash_q   <= squash_d;
            ex_valid_q <= ex_valid_d;
            ex_ctrl_q  <= ex_ctrl_d;
            redirect_q <= redirect_d;
            stall_q    <= stall_d;
            flush_q    <= flush_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign redirect    = redirect_q;
    assign stall_count = stall_q;
    assign flush_count = flush_q;

endmodule

// File: tb/tb_ctrl_pipe_unit.sv
// Bench for ctrl_pipe_unit: directed scenarios plus randomized traffic checked
// against a cycle-level behavioural model of the control stage.
module tb_ctrl_pipe_unit;
    import ctrl_pipe_unit_pkg::*;

    localparam int XLEN  = 32;
    localparam int FLUSH = 2;
    localparam int CNT_W = 4;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   id_valid = 1'b0;
    instruction_format_type opcode = '0;
    instruction_op_type     optype = OPT_R;
    logic [2:0]             funct3 = '0;
    logic [4:0]             rd = '0, rs1 = '0, rs2 = '0;
    logic [XLEN-1:0]        rs1_data = '0, rs2_data = '0;
    logic                   ex_ready = 1'b1;
    logic                   id_stall, ex_valid, redirect;
    ctrl_bundle_t           ex_ctrl;
    logic [CNT_W-1:0]       stall_count, flush_count;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    bit           m_ex_valid;
    ctrl_bundle_t m_ctrl;
    bit           m_redirect;
    int           m_stall, m_flush, m_squash;

    ctrl_pipe_unit #(.XLEN(XLEN), .FLUSH_CYCLES(FLUSH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .opcode(opcode), .optype(optype),
        .funct3(funct3), .rd(rd), .rs1(rs1), .rs2(rs2), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .ex_ready(ex_ready), .id_stall(id_stall), .ex_valid(ex_valid), .ex_ctrl(ex_ctrl),
        .redirect(redirect), .stall_count(stall_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic ctrl_bundle_t model_decode();
        ctrl_bundle_t c;
        bit ld, lui, aui;
        c   = '0;
        ld  = (opcode[6:2] == 5'b00000) || (opcode[6:2] == 5'b00001);
        lui = (opcode[6:2] == 5'b01101);
        aui = (opcode[6:2] == 5'b00101);
        if (!id_valid) return c;
        c.is_compressed = (opcode[1:0] != 2'b11);
        c.rd            = rd;
        c.reg_write     = (optype inside {OPT_R, OPT_I, OPT_J}) || (optype == OPT_U && (lui || aui));
        c.alu_src       = (optype inside {OPT_I, OPT_S}) || (optype == OPT_U && (lui || aui));
        c.auipc         = (optype == OPT_U) && aui;
        c.mem2reg       = (optype == OPT_I) && ld;
        c.load_size     = c.mem2reg ? funct3 : 3'd0;
        c.mem_write     = (optype == OPT_S);
        c.store_size    = (optype == OPT_S) ? funct3 : 3'd0;
        return c;
    endfunction

    function automatic bit model_taken();
        longint sa, sb, ua, ub;
        sa = longint'($signed(rs1_data));
        sb = longint'($signed(rs2_data));
        ua = {32'd0, rs1_data};
        ub = {32'd0, rs2_data};
        if (!id_valid) return 1'b0;
        if (optype == OPT_J) return 1'b1;
        if (optype != OPT_B) return 1'b0;
        case (funct3)
            3'd0: return ua == ub;
            3'd1: return ua != ub;
            3'd4: return sa < sb;
            3'd5: return sa >= sb;
            3'd6: return ua < ub;
            3'd7: return ua >= ub;
            default: return 1'b0;
        endcase
    endfunction

    function automatic bit model_hazard();
        bit r1, r2;
        r1 = (optype inside {OPT_R, OPT_I, OPT_S, OPT_B}) && (rs1 == m_ctrl.rd);
        r2 = (optype inside {OPT_R, OPT_S, OPT_B}) && (rs2 == m_ctrl.rd);
        return id_valid && m_ex_valid && m_ctrl.mem2reg && (m_ctrl.rd != 0) && (r1 || r2);
    endfunction

    function automatic bit model_id_stall();
        return !ex_ready || (m_squash == 0 && model_hazard());
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : CMAX;
    endfunction

    task automatic model_reset();
        m_ex_valid = 0; m_ctrl = '0; m_redirect = 0;
        m_stall = 0; m_flush = 0; m_squash = 0;
    endtask

    task automatic drive(input bit v, input instruction_format_type opc, input instruction_op_type opt,
                         input logic [2:0] f3, input logic [4:0] d, input logic [4:0] s1,
                         input logic [4:0] s2, input logic [31:0] a, input logic [31:0] b);
        id_valid = v; opcode = opc; optype = opt; funct3 = f3;
        rd = d; rs1 = s1; rs2 = s2; rs1_data = a; rs2_data = b;
        #1;
    endtask

    // advance model and DUT by one clock; returns 1 ns after the edge
    task automatic tick();
        ctrl_bundle_t dec;
        bit haz, tk;
        dec = model_decode();
        haz = model_hazard();
        tk  = model_taken();
        m_redirect = 0;
        if (ex_ready) begin
            if (m_squash > 0) begin
                m_ex_valid = 0; m_ctrl = '0;
                if (id_valid) begin m_squash--; m_flush = sat_inc(m_flush); end
            end else if (haz) begin
                m_ex_valid = 0; m_ctrl = '0; m_stall = sat_inc(m_stall);
            end else begin
                m_ex_valid = id_valid; m_ctrl = dec;
                if (tk) begin m_redirect = 1; m_squash = FLUSH; end
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n = 0; ex_ready = 1;
        drive(0, 7'b0110011, OPT_R, 0, 0, 0, 0, 0, 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1;
        n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL reset_ex_valid got=%0b exp=0", ex_valid); end
        n_checks++; if (ex_ctrl !== '0) begin n_fail++; $display("FAIL reset_ex_ctrl got=%h exp=0", ex_ctrl); end
        n_checks++; if (redirect !== 1'b0) begin n_fail++; $display("FAIL reset_redirect got=%0b exp=0", redirect); end
        n_checks++; if (stall_count !== '0 || flush_count !== '0) begin n_fail++; $display("FAIL reset_counts got=%0d/%0d exp=0/0", stall_count, flush_count); end
        n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL reset_id_stall got=%0b exp=0", id_stall); end
    endtask

    task automatic test_branch_compare();
        drive(1, 7'b1100011, OPT_B, BLTU, 0, 1, 2, 32'hFFFF_FFFF, 32'd1);
        n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL bltu_id_stall got=%0b exp=0", id_stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b1 || redirect !== 1'b0) begin n_fail++; $display("FAIL bltu_not_taken valid/redirect got=%0b/%0b exp=1/0", ex_valid, redirect); end
        drive(1, 7'b1100011, OPT_B, BLT, 0, 1, 2, 32'hFFFF_FFFF, 32'd1);
        tick();
        n_checks++; if (redirect !== 1'b1) begin n_fail++; $display("FAIL blt_taken redirect got=%0b exp=1", redirect); end
        for (int i = 0; i < FLUSH; i++) begin
            drive(1, 7'b0110011, OPT_R, 0, 3, 1, 2, 0, 0);
            tick();
            n_checks++; if (ex_valid !== 1'b0 || redirect !== 1'b0) begin n_fail++; $display("FAIL blt_squash%0d valid/redirect got=%0b/%0b exp=0/0", i, ex_valid, redirect); end
        end
        n_checks++; if (flush_count !== CNT_W'(FLUSH)) begin n_fail++; $display("FAIL blt_flush_count got=%0d exp=%0d", flush_count, FLUSH); end
        drive(1, 7'b0110011, OPT_R, 0, 3, 1, 2, 0, 0);
        tick();
        n_checks++; if (ex_valid !== 1'b1 || ex_ctrl.reg_write !== 1'b1 || ex_ctrl.rd !== 5'd3) begin n_fail++; $display("FAIL blt_after_squash got valid=%0b ctrl=%h exp valid=1 rd=3", ex_valid, ex_ctrl); end
    endtask

    task automatic test_load_use();
        drive(1, 7'b0000011, OPT_I, 3'd2, 5, 1, 0, 0, 0);
        tick();
        n_checks++; if (ex_ctrl.mem2reg !== 1'b1 || ex_ctrl.load_size !== 3'd2) begin n_fail++; $display("FAIL load_decode got=%h exp mem2reg=1 size=2", ex_ctrl); end
        drive(1, 7'b0110011, OPT_R, 0, 7, 5, 6, 0, 0);
        n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL load_use_stall got=%0b exp=1", id_stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b0 || stall_count !== CNT_W'(1)) begin n_fail++; $display("FAIL load_use_bubble valid/stalls got=%0b/%0d exp=0/1", ex_valid, stall_count); end
        n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL load_use_release got=%0b exp=0", id_stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b1 || ex_ctrl.rd !== 5'd7) begin n_fail++; $display("FAIL load_use_issue got valid=%0b rd=%0d exp 1/7", ex_valid, ex_ctrl.rd); end
        drive(1, 7'b0000011, OPT_I, 3'd2, 0, 1, 0, 0, 0);
        tick();
        drive(1, 7'b0110011, OPT_R, 0, 7, 0, 6, 0, 0);
        n_checks++; if (id_stall !== 1'b0) begin n_fail++; $display("FAIL load_rd0_no_stall got=%0b exp=0", id_stall); end
        tick();
        n_checks++; if (ex_valid !== 1'b1 || stall_count !== CNT_W'(1)) begin n_fail++; $display("FAIL load_rd0_issue valid/stalls got=%0b/%0d exp=1/1", ex_valid, stall_count); end
    endtask

    task automatic test_jal_squash_hold();
        int f0;
        f0 = m_flush;
        drive(1, 7'b1101111, OPT_J, 0, 1, 0, 0, 0, 0);
        tick();
        n_checks++; if (redirect !== 1'b1 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL jal_issue redirect/valid got=%0b/%0b exp=1/1", redirect, ex_valid); end
        ex_ready = 0;
        for (int i = 0; i < 3; i++) begin
            drive(1, 7'b0110011, OPT_R, 0, 4, 1, 2, 0, 0);
            n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL hold%0d_id_stall got=%0b exp=1", i, id_stall); end
            tick();
            n_checks++; if (ex_ctrl !== m_ctrl || ex_ctrl.rd !== 5'd1 || ex_valid !== 1'b1) begin n_fail++; $display("FAIL hold%0d_ex_ctrl got=%h exp=%h", i, ex_ctrl, m_ctrl); end
        end
        n_checks++; if (redirect !== 1'b0 || flush_count !== CNT_W'(f0)) begin n_fail++; $display("FAIL hold_counts redirect/flush got=%0b/%0d exp=0/%0d", redirect, flush_count, f0); end
        ex_ready = 1;
        for (int i = 0; i < 4; i++) begin
            drive(i != 1, 7'b0110011, OPT_R, 0, 5'(8 + i), 1, 2, 0, 0);
            tick();
            n_checks++; if (ex_valid !== (i == 3)) begin n_fail++; $display("FAIL jal_slot%0d ex_valid got=%0b exp=%0b", i, ex_valid, i == 3); end
        end
        n_checks++; if (flush_count !== CNT_W'(f0 + 2)) begin n_fail++; $display("FAIL jal_flush_count got=%0d exp=%0d", flush_count, f0 + 2); end
    endtask

    task automatic test_reset_mid_squash();
        drive(1, 7'b1101111, OPT_J, 0, 1, 0, 0, 0, 0);
        tick();
        drive(1, 7'b0110011, OPT_R, 0, 4, 1, 2, 0, 0);
        rst_n = 0;
        model_reset();
        #1;
        n_checks++; if (ex_valid !== 1'b0 || ex_ctrl !== '0 || redirect !== 1'b0) begin n_fail++; $display("FAIL async_reset outputs got valid=%0b ctrl=%h redirect=%0b exp all 0", ex_valid, ex_ctrl, redirect); end
        n_checks++; if (stall_count !== '0 || flush_count !== '0) begin n_fail++; $display("FAIL async_reset counts got=%0d/%0d exp=0/0", stall_count, flush_count); end
        #2 rst_n = 1;
        drive(1, 7'b0100011, OPT_S, 3'd1, 0, 2, 3, 0, 0);
        tick();
        n_checks++; if (ex_valid !== 1'b1 || ex_ctrl.mem_write !== 1'b1 || ex_ctrl.store_size !== 3'd1) begin n_fail++; $display("FAIL store_after_reset got valid=%0b ctrl=%h exp mem_write=1 size=1", ex_valid, ex_ctrl); end
        n_checks++; if (ex_ctrl !== m_ctrl) begin n_fail++; $display("FAIL store_ctrl got=%h exp=%h", ex_ctrl, m_ctrl); end
    endtask

    task automatic test_counter_saturation();
        for (int i = 0; i < CMAX + 2; i++) begin
            drive(1, 7'b0000011, OPT_I, 3'd0, 9, 0, 0, 0, 0);
            tick();
            drive(1, 7'b0100011, OPT_S, 3'd2, 0, 1, 9, 0, 0);
            n_checks++; if (id_stall !== 1'b1) begin n_fail++; $display("FAIL sat%0d_stall got=%0b exp=1", i, id_stall); end
            tick();
            tick();
        end
        n_checks++; if (stall_count !== '1) begin n_fail++; $display("FAIL stall_saturate got=%0d exp=%0d", stall_count, CMAX); end
    endtask

    task automatic test_random();
        instruction_format_type i_opc[3];
        instruction_format_type opc;
        instruction_op_type opt;
        logic [31:0] a, b;
        i_opc = '{7'b0000011, 7'b0000111, 7'b0010011};
        for (int c = 0; c < 400; c++) begin
            opt = instruction_op_type'($urandom_range(0, 5));
            case (opt)
                OPT_I:   opc = i_opc[$urandom_range(0, 2)];
                OPT_S:   opc = $urandom_range(0, 1) ? 7'b0100011 : 7'b0100111;
                OPT_B:   opc = 7'b1100011;
                OPT_U:   opc = $urandom_range(0, 1) ? 7'b0110111 : 7'b0010111;
                OPT_J:   opc = 7'b1101111;
                default: opc = 7'b0110011;
            endcase
            if ($urandom_range(0, 3) == 0) opc[1:0] = 2'($urandom_range(0, 2));
            a = $urandom();
            b = $urandom_range(0, 1) ? a : $urandom();
            if ($urandom_range(0, 3) == 0) b = b ^ 32'h8000_0000;
            ex_ready = ($urandom_range(0, 9) < 8);
            drive($urandom_range(0, 9) < 8, opc, opt, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), a, b);
            n_checks++; if (id_stall !== model_id_stall()) begin n_fail++; $display("FAIL rnd%0d id_stall got=%0b exp=%0b", c, id_stall, model_id_stall()); end
            tick();
            n_checks++; if (ex_valid !== m_ex_valid || redirect !== m_redirect) begin n_fail++; $display("FAIL rnd%0d valid/redirect got=%0b/%0b exp=%0b/%0b", c, ex_valid, redirect, m_ex_valid, m_redirect); end
            n_checks++; if (stall_count !== CNT_W'(m_stall) || flush_count !== CNT_W'(m_flush)) begin n_fail++; $display("FAIL rnd%0d counts got=%0d/%0d exp=%0d/%0d", c, stall_count, flush_count, m_stall, m_flush); end
            if (m_ex_valid) begin
                n_checks++; if (ex_ctrl !== m_ctrl) begin n_fail++; $display("FAIL rnd%0d ex_ctrl got=%h exp=%h", c, ex_ctrl, m_ctrl); end
            end
        end
        ex_ready = 1;
    endtask

    initial begin
        test_reset();
        test_branch_compare();
        test_load_use();
        test_jal_squash_hold();
        test_reset_mid_squash();
        test_counter_saturation();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ctrl_pipe_unit.md
# ctrl_pipe_unit

Pipelined, parametrised successor to the combinational decode/control unit. It sits between the ID and EX stages of the RISC-V core and decodes `opcode`/`optype`/`funct3` into a control bundle. It resolves branches in ID with correct signed and unsigned compares, detects load-use hazards, and squashes wrong-path instructions after a taken branch or jump. All EX-side control is delivered through a registered, back-pressurable ID→EX stage.

## Interface
Parameters:
- `XLEN`, default 32: width of register operands.
- `FLUSH_CYCLES`, default 1, range 0..7: number of valid ID instructions squashed after a taken branch.
- `CNT_W`, default 16: width of the saturating performance counters.

Ports:
- `clk`  in  1: single clock; all state on its rising edge.
- `rst_n`  in  1: asynchronous, active-low reset.
- `id_valid`  in  1: ID holds an instruction.
- `opcode`  in  `instruction_format_type`: raw opcode, including bits [1:0].
- `optype`  in  `instruction_op_type`: R/I/S/B/U/J class.
- `funct3`  in  3
- `rd`, `rs1`, `rs2`  in  5 each: register indices.
- `rs1_data`, `rs2_data`  in  `XLEN`: register-file read data.
- `ex_ready`  in  1: EX can accept; 0 holds the EX register.
- `id_stall`  out  1: combinational; ID and fetch must hold.
- `ex_valid`  out  1: EX register holds a real instruction.
- `ex_ctrl`  out  `ctrl_bundle_t`: registered fields `mem_write`, `mem2reg`, `reg_write`, `alu_src`, `auipc`, `is_compressed`, `load_size[2:0]`, `store_size[2:0]`, `rd[4:0]`.
- `redirect`  out  1: registered one-cycle pulse, taken branch/jump.
- `stall_count`, `flush_count`  out  `CNT_W`: saturating counters.

## Operation
- Decode, valid only when `id_valid`:
  - R: `reg_write`.
  - I: `reg_write`, `alu_src`. If also LOAD/LOAD_FP: `mem2reg`, `load_size=funct3`.
  - S (STORE/STORE_FP): `alu_src`, `mem_write`, `store_size=funct3`.
  - U_LUI: `reg_write`, `alu_src`.
  - U_AUIPC: the LUI fields plus `auipc`.
  - J: `reg_write` (link). Branch always taken.
  - `is_compressed = (opcode[1:0] != 2'b11)`.
- Branch conditions:
  - BEQ/BNE compare equality.
  - BLT/BGE compare signed.
  - BLTU/BGEU compare unsigned.
  - Any other `funct3` on a B-type is not taken.
- Register use:
  - `rs1` is used by R, I, S and B.
  - `rs2` is used by R, S and B.
  - U and J use neither.
- Load-use hazard: `ex_valid && ex_ctrl.mem2reg && ex_ctrl.rd != 0` and a used source index equals `ex_ctrl.rd`.
- FSM state `ctrl_state_t`:
  - RUN: normal decode.
  - STALL: hazard bubble.
  - SQUASH: counting off wrong-path instructions.
- Priority each cycle: `!ex_ready` > SQUASH > hazard > RUN.
  - `!ex_ready`: EX register holds, `id_stall=1`, state unchanged, no counting.
  - SQUASH, `id_valid=1`: the ID instruction becomes a bubble (`ex_valid←0`), `squash_cnt` decrements, `flush_count++`. The FSM goes to RUN when `squash_cnt` reaches 0. Cycles with `id_valid=0` do not decrement.
  - Hazard, from RUN: `id_stall=1`, a bubble enters EX, `stall_count++`, state→STALL.
  - STALL: the next cycle re-evaluates the hazard (now clear, since the load left EX) and behaves as RUN.
  - RUN with `id_valid`: the instruction enters EX (`ex_valid←1`, `ex_ctrl←decode`).
    - A taken branch or J sets `redirect` the next cycle.
    - With `FLUSH_CYCLES>0`, it also loads `squash_cnt=FLUSH_CYCLES` and goes to SQUASH.
    - With `FLUSH_CYCLES=0`, the FSM stays in RUN.
- A branch is never resolved while stalled; it resolves on the cycle it is accepted.
- Counters saturate at all-ones; they never wrap.

## Timing
- Reset values: `ex_valid=0`, `ex_ctrl=0`, `redirect=0`, both counters 0, state RUN, `squash_cnt=0`. Reset takes effect immediately, including mid-STALL or mid-SQUASH.
- ID→EX latency: 1 cycle.
- `redirect`: asserted exactly 1 cycle after branch acceptance, for 1 cycle. It is held off while `ex_ready=0` because acceptance itself is held off.
- `id_stall` is purely combinational from current inputs and state: `!ex_ready` OR hazard-in-RUN.
- A hazard and a taken branch on the same instruction: the hazard wins. The branch resolves one cycle later with the forwarded-safe operand.
- `id_valid=0` in RUN: a bubble enters EX, no stall.

## Structure
- Add to `common`:
  - `ctrl_bundle_t` (packed struct).
  - `ctrl_state_t` enum (RUN, STALL, SQUASH).
  - Branch `funct3` constants, reusing the existing BEQ..BGEU.
- Sub-module `branch_compare #(XLEN)`: combinational; inputs `funct3` and the operands; output `taken`. It uses `$signed`/`$unsigned` explicitly.
- Top: decode comb block, hazard comb, FSM and registers.

## Test plan
- BLTU, `rs1=32'hFFFF_FFFF`, `rs2=1` → not taken. BLT with the same operands → taken. `redirect=1` the cycle after, then 1 squash.
- LOAD `rd=5`, followed by ADD with `rs1=5` → `id_stall=1` for 1 cycle, one bubble (`ex_valid=0`), `stall_count=1`, then ADD enters EX.
- LOAD `rd=0`, followed by ADD with `rs1=0` → no stall.
- JAL with `FLUSH_CYCLES=2`, then 3 valid instructions with one `id_valid=0` gap → first two squashed, third issues, `flush_count=2`.
- `ex_ready=0` for 3 cycles during SQUASH → `ex_ctrl` unchanged, `squash_cnt` unchanged, `id_stall=1`.
- Assert `rst_n=0` mid-SQUASH → all outputs zero immediately. After release, the next STORE gives `mem_write=1`, `store_size=funct3`.
